// File: rtl/fifo_check_drain.sv
// fifo_check_drain: drains the shared fifo and checks each word against (k + t).
// FIFO_CHK_STALL_EN: optional every-8th-cycle read stall for backpressure tests.
module fifo_check_drain #(
  parameter int WIDTH = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [31:0]      size,
  input  logic [31:0]      times,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  input  logic             ap_start,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  output logic [31:0]      err_count,
  output logic             first_err_valid,
  output logic [31:0]      first_err_word,
  output logic [31:0]      first_err_pass,
  output logic [WIDTH-1:0] first_err_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [31:0]      size_q, times_q;
  logic [31:0]      word_idx, pass_idx;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_exp;
  logic [31:0]      cmp_word, cmp_pass;
  logic             rd_ok;
  logic             last_word, last_pass;
  logic             mismatch;

`ifdef FIFO_CHK_STALL_EN
  logic [2:0] stall_cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) stall_cnt <= '0;
    else           stall_cnt <= stall_cnt + 3'd1;
  end

  assign rd_ok = !fifo_empty && (stall_cnt != 3'd7);
`else
  assign rd_ok = !fifo_empty;
`endif

  assign last_word = (word_idx == size_q - 32'd1);
  assign last_pass = (pass_idx == times_q - 32'd1);
  assign mismatch  = cmp_valid && (fifo_rd_data != cmp_exp);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n    = state;
    ap_idle    = 1'b0;
    ap_ready   = 1'b0;
    ap_done    = 1'b0;
    fifo_rd_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          ap_ready = 1'b1;
          if (size == 32'd0 || times == 32'd0) state_n = S_DONE;
          else                                 state_n = S_RUN;
        end
      end
      S_RUN: begin
        fifo_rd_en = rd_ok;
        if (rd_ok && last_word && last_pass) state_n = S_FLUSH;
      end
      S_FLUSH: state_n = S_DONE;
      S_DONE: begin
        ap_done = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Nested word/pass counters; no size*times product needed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      size_q   <= '0;
      times_q  <= '0;
      word_idx <= '0;
      pass_idx <= '0;
    end else if (ap_ready) begin
      size_q   <= size;
      times_q  <= times;
      word_idx <= '0;
      pass_idx <= '0;
    end else if (fifo_rd_en) begin
      if (last_word) begin
        word_idx <= '0;
        pass_idx <= pass_idx + 32'd1;
      end else begin
        word_idx <= word_idx + 32'd1;
      end
    end
  end

  // Expectation travels with the read; data lands one cycle later.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_word  <= '0;
      cmp_pass  <= '0;
    end else begin
      cmp_valid <= fifo_rd_en;
      cmp_exp   <= WIDTH'(word_idx + pass_idx);
      cmp_word  <= word_idx;
      cmp_pass  <= pass_idx;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_word  <= '0;
      first_err_pass  <= '0;
      first_err_data  <= '0;
    end else if (ap_ready) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_word  <= '0;
      first_err_pass  <= '0;
      first_err_data  <= '0;
    end else if (mismatch) begin
      if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_word  <= cmp_word;
        first_err_pass  <= cmp_pass;
        first_err_data  <= fifo_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_check_drain.sv
// tb_fifo_check_drain: fifo/generator model, table vectors and random runs
// checked against a pattern model of the checker.
module tb_fifo_check_drain;

  localparam int W = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [31:0]   size = '0;
  logic [31:0]   times = '0;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          ap_start = 1'b0;
  logic          ap_idle, ap_ready, ap_done;
  logic [31:0]   err_count;
  logic          first_err_valid;
  logic [31:0]   first_err_word, first_err_pass;
  logic [W-1:0]  first_err_data;

  fifo_check_drain #(.WIDTH(W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .size(size), .times(times),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_word(first_err_word), .first_err_pass(first_err_pass),
    .first_err_data(first_err_data)
  );

  always #5 ap_clk = ~ap_clk;

  // depth-4 fifo with registered read, fed from the src queue
  logic [W-1:0] fq[$];
  logic [W-1:0] src[$];
  logic [W-1:0] pop_v;
  int push_n = 0, hold_at = 0, hold_left = 0;
  bit fifo_clr = 1'b0;

  always @(posedge ap_clk) begin
    if (fifo_clr) begin
      fq.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() > 0) begin
        pop_v = fq.pop_front();
        fifo_rd_data <= pop_v;
      end
      if (hold_left > 0 && push_n >= hold_at) hold_left = hold_left - 1;
      else if (fq.size() < 4 && src.size() > 0) begin
        fq.push_back(src.pop_front());
        push_n = push_n + 1;
      end
      fifo_empty <= (fq.size() == 0);
    end
  end

  int cyc = 0, rd_cnt = 0, done_cnt = 0, viol = 0;
  int last_rd_cyc = 0, done_cyc = 0;

  always @(negedge ap_clk) begin
    cyc = cyc + 1;
    if (fifo_rd_en) begin
      rd_cnt = rd_cnt + 1;
      last_rd_cyc = cyc;
      if (fifo_empty) viol = viol + 1;
    end
    if (ap_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // pattern stream plus three surplus words that must stay unread
  task automatic build(input int sz, input int tm, output logic [W-1:0] q[$]);
    q.delete();
    for (int t = 0; t < tm; t++)
      for (int k = 0; k < sz; k++) q.push_back(W'(k + t));
    for (int i = 0; i < 3; i++) q.push_back(W'($urandom));
  endtask

  task automatic model(input int sz, input int tm, input logic [W-1:0] d[$],
                       output int e, output bit fv, output int fw,
                       output int fp, output logic [W-1:0] fd);
    logic [W-1:0] ex;
    e = 0; fv = 0; fw = 0; fp = 0; fd = '0;
    for (int t = 0; t < tm; t++)
      for (int k = 0; k < sz; k++) begin
        ex = W'(k + t);
        if (d[t * sz + k] != ex) begin
          e++;
          if (!fv) begin
            fv = 1; fw = k; fp = t; fd = d[t * sz + k];
          end
        end
      end
  endtask

  task automatic load(input logic [W-1:0] d[$], input int hk);
    @(negedge ap_clk);
    fifo_clr = 1'b1;
    @(negedge ap_clk);
    fifo_clr = 1'b0;
    src = d;
    if (hk >= 0) begin
      hold_at = push_n + hk;
      hold_left = 20;
    end
    repeat (6) @(negedge ap_clk);
  endtask

  task automatic run_case(input string nm, input int sz, input int tm,
                          input logic [W-1:0] d[$], input int hk,
                          input int ee, input bit efv, input int efw,
                          input int efp, input logic [W-1:0] efd);
    int total, rd0, dn0, st_cyc, n;
    total = sz * tm;
    load(d, hk);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    size = sz;
    times = tm;
    ap_start = 1'b1;
    #1;
    st_cyc = cyc;
    chk({nm, ".ready"}, ap_ready, 1);
    @(negedge ap_clk);
    ap_start = 1'b0;
    size = $urandom;
    times = $urandom;
    #1;
    chk({nm, ".ready_pulse"}, ap_ready, 0);
    n = 0;
    while (done_cnt == dn0 && n < total * 4 + 100) begin
      @(negedge ap_clk);
      n++;
    end
    chk({nm, ".done_seen"}, done_cnt != dn0, 1);
    repeat (3) @(negedge ap_clk);
    #1;
    chk({nm, ".done_once"}, done_cnt - dn0, 1);
    chk({nm, ".reads"}, rd_cnt - rd0, total);
    if (total > 0) chk({nm, ".lat_last_rd"}, done_cyc - last_rd_cyc, 2);
    else           chk({nm, ".lat_zero"}, done_cyc - st_cyc, 1);
    chk({nm, ".err_count"}, err_count, ee);
    chk({nm, ".first_valid"}, first_err_valid, efv);
    chk({nm, ".first_word"}, first_err_word, efw);
    chk({nm, ".first_pass"}, first_err_pass, efp);
    chk({nm, ".first_data"}, first_err_data, efd);
    chk({nm, ".idle"}, ap_idle, 1);
    chk({nm, ".unread"}, fq.size() + src.size(), 3);
  endtask

  typedef struct {
    string        nm;
    int           sz, tm;
    int           ci0;
    logic [W-1:0] cv0;
    int           ci1;
    logic [W-1:0] cv1;
    int           hk;
    int           ee;
    bit           efv;
    int           efw, efp;
    logic [W-1:0] efd;
  } vec_t;

  vec_t tv[6];

  initial begin
    logic [W-1:0] d[$];
    int e, fw, fp, rd0, dn0, n;
    bit fv;
    logic [W-1:0] fd;
    int sz, tm;

    tv[0] = '{"clean16x3", 16, 3, -1, 8'h00, -1, 8'h00, -1, 0, 0, 0, 0, 8'h00};
    tv[1] = '{"corrupt", 16, 3, 21, 8'hAA, 32, 8'h55, -1, 2, 1, 5, 1, 8'hAA};
    tv[2] = '{"size0", 0, 5, -1, 8'h00, -1, 8'h00, -1, 0, 0, 0, 0, 8'h00};
    tv[3] = '{"wrap300x2", 300, 2, -1, 8'h00, -1, 8'h00, -1, 0, 0, 0, 0, 8'h00};
    tv[4] = '{"hold_empty", 16, 3, -1, 8'h00, -1, 8'h00, 20, 0, 0, 0, 0, 8'h00};
    tv[5] = '{"times0", 7, 0, -1, 8'h00, -1, 8'h00, -1, 0, 0, 0, 0, 8'h00};

    repeat (2) @(negedge ap_clk);
    #1;
    chk("rst.idle", ap_idle, 1);
    chk("rst.ready", ap_ready, 0);
    chk("rst.done", ap_done, 0);
    chk("rst.rd_en", fifo_rd_en, 0);
    chk("rst.err", err_count, 0);
    chk("rst.fv", first_err_valid, 0);
    chk("rst.fw", first_err_word, 0);
    chk("rst.fp", first_err_pass, 0);
    chk("rst.fd", first_err_data, 0);
    ap_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      build(tv[i].sz, tv[i].tm, d);
      if (tv[i].ci0 >= 0) d[tv[i].ci0] = tv[i].cv0;
      if (tv[i].ci1 >= 0) d[tv[i].ci1] = tv[i].cv1;
      run_case(tv[i].nm, tv[i].sz, tv[i].tm, d, tv[i].hk, tv[i].ee,
               tv[i].efv, tv[i].efw, tv[i].efp, tv[i].efd);
    end

    // reset in the middle of a run that already has an error
    build(16, 3, d);
    d[2] = 8'hEE;
    load(d, -1);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    size = 16;
    times = 3;
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    n = 0;
    while (rd_cnt - rd0 < 10 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    chk("mid.reads_reached", rd_cnt - rd0 >= 10, 1);
    #1;
    chk("mid.pre_err", err_count, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("mid.idle", ap_idle, 1);
    chk("mid.rd_en", fifo_rd_en, 0);
    chk("mid.err", err_count, 0);
    chk("mid.fv", first_err_valid, 0);
    chk("mid.fd", first_err_data, 0);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    chk("mid.no_done", done_cnt - dn0, 0);
    build(4, 1, d);
    run_case("restart4x1", 4, 1, d, -1, 0, 0, 0, 0, 8'h00);

    // random runs against the pattern model
    for (int r = 0; r < 10; r++) begin
      sz = $urandom_range(1, 24);
      tm = $urandom_range(1, 4);
      build(sz, tm, d);
      for (int i = 0; i < sz * tm; i++)
        if ($urandom_range(0, 9) == 0) d[i] = W'($urandom);
      model(sz, tm, d, e, fv, fw, fp, fd);
      run_case($sformatf("rnd%0d", r), sz, tm, d,
               ($urandom_range(0, 2) == 0) ? 5 : -1, e, fv, fw, fp, fd);
    end

    chk("rd_while_empty", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
